// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the instruction-decode stage.
// Holds the instruction format codes (which double as the immediate-format
// selector for imm_gen), the RV32/RV64 base opcode constants, and a helper that
// maps an opcode to its format.
package id_stage_pkg;

  // Format code; also selects the immediate layout in imm_gen.
  typedef enum logic [2:0] {
    TypeR    = 3'd0,
    TypeI    = 3'd1,
    TypeS    = 3'd2,
    TypeB    = 3'd3,
    TypeU    = 3'd4,
    TypeJ    = 3'd5,
    TypeNone = 3'd7
  } inst_type_e;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  function automatic inst_type_e decode_type(logic [6:0] opcode);
    inst_type_e t;
    case (opcode)
      OpReg:                  t = TypeR;
      OpImm, OpLoad, OpJalr:  t = TypeI;
      OpStore:                t = TypeS;
      OpBranch:               t = TypeB;
      OpLui, OpAuipc:         t = TypeU;
      OpJal:                  t = TypeJ;
      default:                t = TypeNone;
    endcase
    return t;
  endfunction

  // Formats that write a destination register.
  function automatic logic type_writes_rd(inst_type_e t);
    return (t == TypeR) || (t == TypeI) || (t == TypeU) || (t == TypeJ);
  endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Immediate generator: purely combinational.
// Ports:
//   inst_i       32-bit instruction word
//   inst_type_i  format code selecting the immediate layout
//   imm_o        XLEN-bit immediate, sign-extended from inst_i[31]; 0 for R/NONE
module imm_gen
  import id_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst_i,
  input  inst_type_e      inst_type_i,
  output logic [XLEN-1:0] imm_o
);

  // Each layout is assembled at its natural width as a signed value; the
  // size cast to XLEN performs the sign extension.
  always_comb begin
    imm_o = '0;
    case (inst_type_i)
      TypeI: imm_o = XLEN'($signed(inst_i[31:20]));
      TypeS: imm_o = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
      TypeB: imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
      TypeU: imm_o = XLEN'($signed({inst_i[31:12], 12'b0}));
      TypeJ: imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21],
                                    1'b0}));
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode pipeline stage with a single-entry valid/ready output
// register.
// Ports:
//   clk_i, rst_i                 clock; asynchronous active-low reset
//   if_valid_i / if_ready_o      handshake with fetch
//   pc_i, inst_i                 fetched PC and instruction word
//   reg_addr1_o, reg_addr2_o     combinational rs1/rs2 read addresses
//   reg_data1_i, reg_data2_i     same-cycle regfile read data
//   flush_i                      squash held and arriving instruction
//   ex_ready_i / ex_valid_o      handshake with execute
//   pc_o, op1_o, op2_o, imm_o    registered PC, operands and immediate
//   rd_addr_o, rd_we_o           destination and write enable
//   inst_type_o                  format code (inst_type_e)
//   funct3_o, funct7b5_o         inst[14:12] and inst[30]
//   illegal_o                    unsupported opcode
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_valid_i,
  output logic             if_ready_o,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      inst_i,
  output logic [RF_AW-1:0] reg_addr1_o,
  output logic [RF_AW-1:0] reg_addr2_o,
  input  logic [XLEN-1:0]  reg_data1_i,
  input  logic [XLEN-1:0]  reg_data2_i,
  input  logic             flush_i,
  input  logic             ex_ready_i,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  op1_o,
  output logic [XLEN-1:0]  op2_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [RF_AW-1:0] rd_addr_o,
  output logic             rd_we_o,
  output logic [2:0]       inst_type_o,
  output logic [2:0]       funct3_o,
  output logic             funct7b5_o,
  output logic             illegal_o
);

  inst_type_e      dec_type;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rd_we;
  logic            accept;

  logic             ex_valid_q;
  logic [XLEN-1:0]  pc_q, op1_q, op2_q, imm_q;
  logic [RF_AW-1:0] rd_addr_q;
  logic             rd_we_q;
  inst_type_e       inst_type_q;
  logic [2:0]       funct3_q;
  logic             funct7b5_q;
  logic             illegal_q;

  // Read addresses go straight to the regfile so its data lines up with inst_i.
  assign reg_addr1_o = RF_AW'(inst_i[19:15]);
  assign reg_addr2_o = RF_AW'(inst_i[24:20]);

  assign dec_type  = decode_type(inst_i[6:0]);
  assign dec_rd_we = type_writes_rd(dec_type) && (inst_i[11:7] != 5'd0);

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .inst_i     (inst_i),
    .inst_type_i(dec_type),
    .imm_o      (dec_imm)
  );

  assign if_ready_o = (!ex_valid_q || ex_ready_i) && !flush_i;
  assign accept     = if_valid_i && if_ready_o;

  // Priority: flush, then accept, then drain. With a stalled held instruction
  // if_ready_o is low, so no branch fires and every register holds.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid_q  <= 1'b0;
      pc_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      imm_q       <= '0;
      rd_addr_q   <= '0;
      rd_we_q     <= 1'b0;
      inst_type_q <= TypeNone;
      funct3_q    <= '0;
      funct7b5_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;
      rd_we_q    <= 1'b0;
    end else if (accept) begin
      ex_valid_q  <= 1'b1;
      pc_q        <= pc_i;
      op1_q       <= reg_data1_i;
      op2_q       <= reg_data2_i;
      imm_q       <= dec_imm;
      rd_addr_q   <= RF_AW'(inst_i[11:7]);
      rd_we_q     <= dec_rd_we;
      inst_type_q <= dec_type;
      funct3_q    <= inst_i[14:12];
      funct7b5_q  <= inst_i[30];
      illegal_q   <= (dec_type == TypeNone);
    end else if (ex_ready_i) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid_o  = ex_valid_q;
  assign pc_o        = pc_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign imm_o       = imm_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_we_o     = rd_we_q;
  assign inst_type_o = inst_type_q;
  assign funct3_o    = funct3_q;
  assign funct7b5_o  = funct7b5_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
  import id_stage_pkg::*;

  logic        clk, rst_n;
  logic        if_valid, flush, ex_ready;
  logic [31:0] pc, inst, d1, d2;

  logic        if_ready, ex_valid, rd_we, illegal, f7;
  logic [4:0]  ra1, ra2, rd_addr;
  logic [31:0] pc_o, op1, op2, imm;
  logic [2:0]  typ, f3;

  logic        if_ready64, ex_valid64, rd_we64, illegal64, f7_64;
  logic [4:0]  ra1_64, ra2_64, rd_addr64;
  logic [63:0] pc_o64, op1_64, op2_64, imm64;
  logic [2:0]  typ64, f3_64;

  int n_checks = 0;
  int n_fail   = 0;

  id_stage #(.XLEN(32), .RF_AW(5)) dut (
    .clk_i(clk), .rst_i(rst_n), .if_valid_i(if_valid), .if_ready_o(if_ready),
    .pc_i(pc), .inst_i(inst), .reg_addr1_o(ra1), .reg_addr2_o(ra2),
    .reg_data1_i(d1), .reg_data2_i(d2), .flush_i(flush), .ex_ready_i(ex_ready),
    .ex_valid_o(ex_valid), .pc_o(pc_o), .op1_o(op1), .op2_o(op2), .imm_o(imm),
    .rd_addr_o(rd_addr), .rd_we_o(rd_we), .inst_type_o(typ), .funct3_o(f3),
    .funct7b5_o(f7), .illegal_o(illegal)
  );

  id_stage #(.XLEN(64), .RF_AW(5)) dut64 (
    .clk_i(clk), .rst_i(rst_n), .if_valid_i(if_valid), .if_ready_o(if_ready64),
    .pc_i({32'h0, pc}), .inst_i(inst), .reg_addr1_o(ra1_64), .reg_addr2_o(ra2_64),
    .reg_data1_i({32'h0, d1}), .reg_data2_i({32'h0, d2}), .flush_i(flush),
    .ex_ready_i(ex_ready), .ex_valid_o(ex_valid64), .pc_o(pc_o64), .op1_o(op1_64),
    .op2_o(op2_64), .imm_o(imm64), .rd_addr_o(rd_addr64), .rd_we_o(rd_we64),
    .inst_type_o(typ64), .funct3_o(f3_64), .funct7b5_o(f7_64), .illegal_o(illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode, straight from the opcode table and field layouts.
  function automatic logic [2:0] ref_type(input logic [6:0] op);
    case (op)
      7'h33:               return TypeR;
      7'h13, 7'h03, 7'h67: return TypeI;
      7'h23:               return TypeS;
      7'h63:               return TypeB;
      7'h37, 7'h17:        return TypeU;
      7'h6F:               return TypeJ;
      default:             return TypeNone;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] w);
    longint s;
    s = longint'($signed(w));
    case (ref_type(w[6:0]))
      TypeI: return s >>> 20;
      TypeS: return ((s >>> 25) << 5) | longint'(w[11:7]);
      TypeB: return ((s >>> 31) << 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5)
                    | (longint'(w[11:8]) << 1);
      TypeU: return s & 64'hFFFF_FFFF_FFFF_F000;
      TypeJ: return ((s >>> 31) << 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11)
                    | (longint'(w[30:21]) << 1);
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic ref_we(input logic [31:0] w);
    logic [2:0] t;
    t = ref_type(w[6:0]);
    return (t == TypeR || t == TypeI || t == TypeU || t == TypeJ) && (w[11:7] != 0);
  endfunction

  typedef struct {
    logic [31:0] inst, pc, d1, d2;
    logic [2:0]  typ;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        we, ill;
    logic [2:0]  f3;
    logic        f7;
  } vec_t;

  vec_t vecs[10];

  // Model of the held instruction.
  logic        m_valid, m_we, m_ill, m_f7, m_flushed;
  logic [31:0] m_pc, m_op1, m_op2;
  logic [63:0] m_imm;
  logic [4:0]  m_rd;
  logic [2:0]  m_type, m_f3;

  initial begin
    vecs[0] = '{32'h00500093, 32'h100, 32'h0,  32'h0,  TypeI, 64'h5,                  5'd1,  1, 0, 3'd0, 0};
    vecs[1] = '{32'hFFF00113, 32'h104, 32'h1,  32'h2,  TypeI, 64'hFFFFFFFF_FFFFFFFF,  5'd2,  1, 0, 3'd0, 1};
    vecs[2] = '{32'h0020A423, 32'h108, 32'h20, 32'hAB, TypeS, 64'h8,                  5'd8,  0, 0, 3'd2, 0};
    vecs[3] = '{32'h0000007F, 32'h10C, 32'h3,  32'h4,  TypeNone, 64'h0,               5'd0,  0, 1, 3'd0, 0};
    vecs[4] = '{32'h123452B7, 32'h110, 32'h5,  32'h6,  TypeU, 64'h12345000,           5'd5,  1, 0, 3'd5, 0};
    vecs[5] = '{32'hFFDFF0EF, 32'h114, 32'h7,  32'h8,  TypeJ, 64'hFFFFFFFF_FFFFFFFC,  5'd1,  1, 0, 3'd7, 1};
    vecs[6] = '{32'hFE208CE3, 32'h118, 32'h9,  32'hA,  TypeB, 64'hFFFFFFFF_FFFFFFF8,  5'd25, 0, 0, 3'd0, 1};
    vecs[7] = '{32'h402081B3, 32'h11C, 32'h55, 32'h77, TypeR, 64'h0,                  5'd3,  1, 0, 3'd0, 1};
    vecs[8] = '{32'h00000013, 32'h120, 32'h0,  32'h0,  TypeI, 64'h0,                  5'd0,  0, 0, 3'd0, 0};
    vecs[9] = '{32'h00008067, 32'h124, 32'hC,  32'hD,  TypeI, 64'h0,                  5'd0,  0, 0, 3'd0, 0};

    rst_n = 1'b0; if_valid = 0; flush = 0; ex_ready = 0;
    pc = 32'hDEAD; inst = 32'h00500093; d1 = 32'h1; d2 = 32'h2;
    tick(); tick();
    check("reset ex_valid", ex_valid, 0);
    check("reset pc", pc_o, 0);
    check("reset imm", imm, 0);
    check("reset type", typ, TypeNone);
    check("reset rd_we", rd_we, 0);
    check("reset illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle ex_valid", ex_valid, 0);

    // Table-driven decode, back to back with execute always ready.
    foreach (vecs[i]) begin
      inst = vecs[i].inst; pc = vecs[i].pc; d1 = vecs[i].d1; d2 = vecs[i].d2;
      if_valid = 1; ex_ready = 1;
      #1;
      check("tbl reg_addr1", ra1, vecs[i].inst[19:15]);
      check("tbl reg_addr2", ra2, vecs[i].inst[24:20]);
      check("tbl if_ready", if_ready, 1);
      tick();
      check("tbl ex_valid", ex_valid, 1);
      check("tbl pc", pc_o, vecs[i].pc);
      check("tbl op1", op1, vecs[i].d1);
      check("tbl op2", op2, vecs[i].d2);
      check("tbl imm32", imm, vecs[i].imm[31:0]);
      check("tbl imm64", imm64, vecs[i].imm);
      check("tbl type", typ, vecs[i].typ);
      check("tbl rd_we", rd_we, vecs[i].we);
      check("tbl illegal", illegal, vecs[i].ill);
      check("tbl funct3", f3, vecs[i].f3);
      check("tbl funct7b5", f7, vecs[i].f7);
      if (vecs[i].we) check("tbl rd_addr", rd_addr, vecs[i].rd);
    end

    // Drain: no new instruction, execute ready.
    if_valid = 0;
    tick();
    check("drain ex_valid", ex_valid, 0);

    // Stall for 3 cycles with a pending instruction, then release.
    inst = 32'h00500093; pc = 32'h200; if_valid = 1; ex_ready = 1;
    tick();
    inst = 32'h00A00113; pc = 32'h204; ex_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall if_ready", if_ready, 0);
      tick();
      check("stall ex_valid", ex_valid, 1);
      check("stall pc", pc_o, 32'h200);
      check("stall imm", imm, 5);
      check("stall rd_addr", rd_addr, 1);
    end
    ex_ready = 1;
    #1;
    check("unstall if_ready", if_ready, 1);
    tick();
    check("unstall ex_valid", ex_valid, 1);
    check("unstall pc", pc_o, 32'h204);
    check("unstall imm", imm, 10);
    inst = 32'h00100193; pc = 32'h208;
    tick();
    check("next pc", pc_o, 32'h208);

    // Flush with held instruction and a new one arriving.
    ex_ready = 0; inst = 32'h00500093; pc = 32'h300; flush = 1;
    #1;
    check("flush if_ready", if_ready, 0);
    tick();
    check("flush ex_valid", ex_valid, 0);
    check("flush rd_we", rd_we, 0);
    flush = 0;
    tick();
    check("post-flush accept", pc_o, 32'h300);

    // Reset dropped mid-stall: outputs clear without a clock edge.
    ex_ready = 0; inst = 32'h00700213; pc = 32'h400;
    tick();
    check("pre-reset held", pc_o, 32'h300);
    rst_n = 0;
    #1;
    check("async reset ex_valid", ex_valid, 0);
    check("async reset pc", pc_o, 0);
    check("async reset op1", op1, 0);
    check("async reset type", typ, TypeNone);
    check("async reset rd_we", rd_we, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    check("post-reset ex_valid", ex_valid, 1);
    check("post-reset pc", pc_o, 32'h400);

    // Randomized traffic against the model.
    if_valid = 0; ex_ready = 1; flush = 0;
    tick();
    m_valid = 0; m_we = 0; m_ill = 0; m_f7 = 0; m_flushed = 0;
    m_pc = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_rd = 0; m_type = TypeNone; m_f3 = 0;
    for (int c = 0; c < 500; c++) begin
      logic [6:0] ops [10];
      logic exp_rdy;
      ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
      inst = {$urandom(), 7'h0};
      inst[6:0] = ($urandom_range(0, 9) == 9) ? 7'($urandom()) : ops[$urandom_range(0, 8)];
      pc = $urandom(); d1 = $urandom(); d2 = $urandom();
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 11) == 0);
      #1;
      exp_rdy = (!m_valid || ex_ready) && !flush;
      check("rnd if_ready", if_ready, exp_rdy);
      check("rnd reg_addr1", ra1, inst[19:15]);
      check("rnd reg_addr2", ra2, inst[24:20]);
      m_flushed = flush;
      if (flush) begin
        m_valid = 0; m_we = 0;
      end else if (if_valid && exp_rdy) begin
        m_valid = 1; m_pc = pc; m_op1 = d1; m_op2 = d2; m_imm = ref_imm(inst);
        m_rd = inst[11:7]; m_we = ref_we(inst); m_type = ref_type(inst[6:0]);
        m_ill = (m_type == TypeNone); m_f3 = inst[14:12]; m_f7 = inst[30];
      end else if (ex_ready) begin
        m_valid = 0;
      end
      tick();
      check("rnd ex_valid", ex_valid, m_valid);
      check("rnd ex_valid64", ex_valid64, m_valid);
      if (m_valid || m_flushed) check("rnd rd_we", rd_we, m_we);
      if (m_valid) begin
        check("rnd pc", pc_o, m_pc);
        check("rnd op1", op1, m_op1);
        check("rnd op2", op2, m_op2);
        check("rnd imm32", imm, m_imm[31:0]);
        check("rnd imm64", imm64, m_imm);
        check("rnd pc64", pc_o64, {32'h0, m_pc});
        check("rnd type", typ, m_type);
        check("rnd illegal", illegal, m_ill);
        check("rnd funct3", f3, m_f3);
        check("rnd funct7b5", f7, m_f7);
        if (m_we) check("rnd rd_addr", rd_addr, m_rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter XLEN, default 32, SHALL set datapath width; legal values 32 and 64.
REQ-002 Parameter RF_AW, default 5, SHALL set register address width.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset: asynchronous assert, active-low, released synchronously to clk_i.
REQ-005 if_valid_i  input  1  SHALL qualify pc_i/inst_i from fetch.
REQ-006 if_ready_o  output  1  SHALL indicate the stage accepts an instruction this cycle.
REQ-007 pc_i  input  XLEN  SHALL carry the fetched instruction address.
REQ-008 inst_i  input  32  SHALL carry the fetched instruction word.
REQ-009 reg_addr1_o, reg_addr2_o  output  RF_AW each  SHALL carry the rs1/rs2 read addresses to the regfile.
REQ-010 reg_data1_i, reg_data2_i  input  XLEN each  SHALL carry the same-cycle regfile read data.
REQ-011 flush_i  input  1  SHALL squash the held instruction and any instruction arriving that cycle.
REQ-012 ex_ready_i  input  1  SHALL indicate execute accepts the held instruction.
REQ-013 ex_valid_o  output  1  SHALL qualify every output to execute.
REQ-014 pc_o, op1_o, op2_o, imm_o  output  XLEN each  SHALL carry the registered PC, rs1 data, rs2 data and immediate.
REQ-015 rd_addr_o  output  RF_AW; rd_we_o  output  1  SHALL carry the destination and its write enable.
REQ-016 inst_type_o  output  3  SHALL carry the format code (R/I/S/B/U/J/NONE) from the shared package.
REQ-017 funct3_o  output  3; funct7b5_o  output  1  SHALL carry inst[14:12] and inst[30].
REQ-018 illegal_o  output  1  SHALL flag an unsupported opcode.

Function
REQ-019 reg_addr1_o/reg_addr2_o SHALL be combinational from inst_i[19:15]/[24:20] so regfile data arrives in the same cycle as inst_i.
REQ-020 if_ready_o SHALL equal (!ex_valid_o || ex_ready_i) && !flush_i.
REQ-021 Accept SHALL occur when if_valid_i && if_ready_o; one accept gives ex_valid_o=1 and all outputs updated on the next edge (latency 1).
REQ-022 When ex_valid_o && !ex_ready_i, every output SHALL hold its value unchanged.
REQ-023 When ex_ready_i is high and no accept occurs, ex_valid_o SHALL fall to 0 next edge; the data outputs may retain stale values.
REQ-024 flush_i SHALL force ex_valid_o=0 and rd_we_o=0 next edge regardless of if_valid_i or ex_ready_i.
REQ-025 Immediates SHALL be sign-extended to XLEN from inst[31]: I {31:20}; S {31:25,11:7}; B {31,7,30:25,11:8,0}; U {31:12,12'b0}; J {31,19:12,20,30:21,0}; R/NONE give 0.
REQ-026 Opcode mapping SHALL be: 0110011 R; 0010011, 0000011, 1100111 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J; other NONE with illegal_o=1.
REQ-027 rd_we_o SHALL be 1 for R, I, U, J formats and 0 for S, B, NONE; forced 0 when rd_addr is 0.
REQ-028 illegal_o, rd_we_o and inst_type_o SHALL be meaningful only while ex_valid_o=1.

Reset
REQ-029 While rst_i=0, ex_valid_o, rd_we_o, illegal_o SHALL be 0, all data outputs 0, inst_type_o NONE, independent of clk_i.
REQ-030 Reset asserted mid-transfer SHALL discard the held instruction; first accept allowed on the first edge after release.

Structure
REQ-031 Format codes, opcode constants and the immediate-format enumeration SHALL live in the shared package with defines.v.
REQ-032 Immediate generation SHALL be one combinational sub-module, imm_gen, instantiated once.

Verification
REQ-033 addi x1,x0,5 (0x00500093), pc 0x100, ex_ready=1 -> next cycle ex_valid=1, pc_o=0x100, imm_o=5, rd_addr_o=1, rd_we_o=1, type I.
REQ-034 addi x2,x0,-1 (0xFFF00113) -> imm_o=0xFFFFFFFF (XLEN=32) and 0xFFFFFFFFFFFFFFFF (XLEN=64).
REQ-035 sw x2,8(x1) (0x0020A423) with reg_data1=0x20, reg_data2=0xAB -> imm_o=8, op1_o=0x20, op2_o=0xAB, rd_we_o=0, type S.
REQ-036 Hold ex_ready=0 for 3 cycles with if_valid=1 -> if_ready_o=0, outputs constant; ex_ready=1 -> next instruction appears one edge later, none lost or duplicated.
REQ-037 flush_i=1 with held instruction and if_valid=1 -> next edge ex_valid_o=0, rd_we_o=0; opcode 0x0000007F -> illegal_o=1, rd_we_o=0.
REQ-038 Drop rst_i mid-stall -> outputs zero immediately without clock edge; release -> normal accept on next edge.
